// File: rtl/sod_pkg.sv
// sod_pkg: shared mode encodings and pointer-width helper for set_output_delay_multi.
`default_nettype none

package sod_pkg;

  localparam logic SOD_MODE_RR = 1'b0;
  localparam logic SOD_MODE_BC = 1'b1;

  // A one-channel build still needs a 1-bit pointer register.
  function automatic int sod_ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sod_pin_chan.sv
// sod_pin_chan: one output channel, a DEPTH-stage valid/data pipeline with the capture stage exposed as pin_q.
`default_nettype none

module sod_pin_chan #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 2,
  parameter bit INVERT = 1'b0
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] pin_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] cap_data;

  assign cap_data = INVERT ? ~in_data : in_data;

  // Data stages only load behind a valid, so the port holds its last delivered value.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) data_q[0] <= cap_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign pin_q     = data_q[0];
  assign out_data  = data_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sod_ref_ff.sv
// sod_ref_ff: free-running reference flop whose clock pin anchors -reference_pin constraints.
`default_nettype none

module sod_ref_ff #(
  parameter int WIDTH = 4
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/set_output_delay_multi.sv
// set_output_delay_multi: round-robin/broadcast distributor feeding NUM_CH registered output channels,
// plus an accepted-sample counter and a reference flop.
`default_nettype none

module set_output_delay_multi
  import sod_pkg::*;
#(
  parameter int                WIDTH       = 4,
  parameter int                NUM_CH      = 4,
  parameter int                DEPTH       = 2,
  parameter logic [NUM_CH-1:0] INVERT_MASK = 'b1010,
  parameter int                CNT_W       = 8
) (
  input  logic                    src_clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    data_valid,
  input  logic                    mode,
  output logic [NUM_CH*WIDTH-1:0] port_out,
  output logic [NUM_CH-1:0]       port_valid,
  output logic [WIDTH-1:0]        ref_q,
  output logic [CNT_W-1:0]        sample_cnt
);

  localparam int PTR_W = sod_ptr_w(NUM_CH);

  logic [PTR_W-1:0] rr_ptr;
  logic [NUM_CH-1:0] route;
  // Capture-stage pins exist as SDC targets; nothing at this level consumes them.
  logic [WIDTH-1:0] chan_pin_unused [NUM_CH];

  always_comb begin
    route = '0;
    for (int c = 0; c < NUM_CH; c++)
      route[c] = data_valid && ((mode == SOD_MODE_BC) || (rr_ptr == PTR_W'(c)));
  end

  // Broadcast samples leave the pointer frozen so RR resumes where it stopped.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      sample_cnt <= '0;
    end else if (data_valid) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (mode == SOD_MODE_RR)
        rr_ptr <= (rr_ptr == PTR_W'(NUM_CH - 1)) ? '0 : rr_ptr + PTR_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    sod_pin_chan #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .INVERT (INVERT_MASK[c])
    ) u_chan (
      .src_clk   (src_clk),
      .rst       (rst),
      .in_valid  (route[c]),
      .in_data   (data_in),
      .pin_q     (chan_pin_unused[c]),
      .out_data  (port_out[c*WIDTH +: WIDTH]),
      .out_valid (port_valid[c])
    );
  end

  sod_ref_ff #(
    .WIDTH (WIDTH)
  ) ff_ref (
    .src_clk (src_clk),
    .rst     (rst),
    .d       (data_in),
    .q       (ref_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_set_output_delay_multi.sv
// tb_set_output_delay_multi: scoreboard bench over four builds sharing one stimulus stream with separate resets.
`default_nettype none

module tb_set_output_delay_multi;
  import sod_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic data_valid = 1'b0;
  logic mode = SOD_MODE_RR;

  logic [15:0] a_port_out, b_port_out, c_port_out;
  logic [3:0]  a_port_valid, b_port_valid, c_port_valid;
  logic [3:0]  a_ref_q, b_ref_q, c_ref_q, d_ref_q, d_port_out;
  logic [0:0]  d_port_valid;
  logic [7:0]  a_cnt, c_cnt, d_cnt;
  logic [2:0]  b_cnt;

  int checks = 0, failures = 0, cyc = 0, cnt_a = 0, rr_m = 0;

  typedef struct { int due; int ch; logic [3:0] val; } exp_t;
  exp_t exp_q[$];
  logic [3:0] last_val [4] = '{default: 4'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  set_output_delay_multi #(.WIDTH(4), .NUM_CH(4), .DEPTH(2), .INVERT_MASK(4'b1010), .CNT_W(8)) dut_a (
    .src_clk(clk), .rst(rst_a), .data_in(data_in), .data_valid(data_valid), .mode(mode),
    .port_out(a_port_out), .port_valid(a_port_valid), .ref_q(a_ref_q), .sample_cnt(a_cnt));

  set_output_delay_multi #(.WIDTH(4), .NUM_CH(4), .DEPTH(2), .INVERT_MASK(4'b1010), .CNT_W(3)) dut_b (
    .src_clk(clk), .rst(rst_b), .data_in(data_in), .data_valid(data_valid), .mode(mode),
    .port_out(b_port_out), .port_valid(b_port_valid), .ref_q(b_ref_q), .sample_cnt(b_cnt));

  set_output_delay_multi #(.WIDTH(4), .NUM_CH(4), .DEPTH(3), .INVERT_MASK(4'b1010), .CNT_W(8)) dut_c (
    .src_clk(clk), .rst(rst_c), .data_in(data_in), .data_valid(data_valid), .mode(mode),
    .port_out(c_port_out), .port_valid(c_port_valid), .ref_q(c_ref_q), .sample_cnt(c_cnt));

  set_output_delay_multi #(.WIDTH(4), .NUM_CH(1), .DEPTH(1), .INVERT_MASK(1'b1), .CNT_W(8)) dut_d (
    .src_clk(clk), .rst(rst_d), .data_in(data_in), .data_valid(data_valid), .mode(mode),
    .port_out(d_port_out), .port_valid(d_port_valid), .ref_q(d_ref_q), .sample_cnt(d_cnt));

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one cycle and records what build A must deliver two edges later.
  task automatic drive(input logic v, input logic [3:0] d, input logic m);
    exp_t e;
    data_valid = v; data_in = d; mode = m;
    if (v && !rst_a) begin
      cnt_a++;
      for (int c = 0; c < 4; c++) begin
        if (m == SOD_MODE_BC || c == rr_m) begin
          e.due = cyc + 2; e.ch = c; e.val = (c % 2 == 1) ? ~d : d;
          exp_q.push_back(e);
        end
      end
      if (m == SOD_MODE_RR) rr_m = (rr_m + 1) % 4;
    end
    step();
  endtask

  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t e;
    if (!rst_a) begin
      ev = '0;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        ev[e.ch] = 1'b1;
        last_val[e.ch] = e.val;
      end
      checks++;
      if (a_port_valid !== ev) begin
        failures++; $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, a_port_valid, ev);
      end
      checks++;
      if (a_port_out !== {last_val[3], last_val[2], last_val[1], last_val[0]}) begin
        failures++;
        $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, a_port_out,
                 {last_val[3], last_val[2], last_val[1], last_val[0]});
      end
    end
  end

  task automatic test_reset();
    data_in = 4'hF;
    step();
    checks++; if (a_port_out !== 16'h0) begin failures++; $display("FAIL rst_port_out got=%h exp=0", a_port_out); end
    checks++; if (a_port_valid !== 4'h0) begin failures++; $display("FAIL rst_port_valid got=%b exp=0", a_port_valid); end
    checks++; if (a_ref_q !== 4'h0) begin failures++; $display("FAIL rst_ref_q got=%h exp=0", a_ref_q); end
    checks++; if (a_cnt !== 8'h0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    checks++; if (d_port_out !== 4'h0) begin failures++; $display("FAIL rst_d_port got=%h exp=0", d_port_out); end
    data_in = 4'h0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    step();
  endtask

  task automatic test_rr();
    for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i), SOD_MODE_RR);
    drive(1'b0, 4'h0, SOD_MODE_RR);
    drive(1'b0, 4'h0, SOD_MODE_RR);
    checks++; if (a_port_out !== 16'hB3D5) begin failures++; $display("FAIL rr_ports got=%h exp=b3d5", a_port_out); end
    checks++; if (a_cnt !== 8'd5) begin failures++; $display("FAIL rr_cnt got=%0d exp=5", a_cnt); end
  endtask

  task automatic test_broadcast();
    drive(1'b1, 4'h6, SOD_MODE_BC);
    drive(1'b1, 4'hC, SOD_MODE_RR);
    checks++; if (a_port_valid !== 4'hF) begin failures++; $display("FAIL bc_valid got=%b exp=1111", a_port_valid); end
    checks++; if (a_port_out !== 16'h9696) begin failures++; $display("FAIL bc_ports got=%h exp=9696", a_port_out); end
    drive(1'b0, 4'h0, SOD_MODE_RR);
    checks++; if (a_port_valid !== 4'b0010) begin failures++; $display("FAIL bc_resume_ptr got=%b exp=0010", a_port_valid); end
    checks++; if (a_port_out[7:4] !== 4'h3) begin failures++; $display("FAIL bc_resume_data got=%h exp=3", a_port_out[7:4]); end
  endtask

  task automatic test_gaps();
    logic [3:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 4'(10 + i);
      drive(1'b0, d, SOD_MODE_RR);
      checks++; if (a_ref_q !== d) begin failures++; $display("FAIL gap_ref_q got=%h exp=%h", a_ref_q, d); end
      checks++; if (a_cnt !== 8'd7) begin failures++; $display("FAIL gap_cnt got=%0d exp=7", a_cnt); end
      checks++; if (a_port_out !== 16'h9636) begin failures++; $display("FAIL gap_hold got=%h exp=9636", a_port_out); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ev;
    rst_b = 1'b1; step(); rst_b = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'(i), SOD_MODE_RR);
      if (i > 0) begin
        ev = 4'(1 << ((i - 1) % 4));
        checks++; if (b_port_valid !== ev) begin failures++; $display("FAIL wrap_ch i=%0d got=%b exp=%b", i, b_port_valid, ev); end
      end
    end
    drive(1'b0, 4'h0, SOD_MODE_RR);
    checks++; if (b_port_valid !== 4'b0001) begin failures++; $display("FAIL wrap_last got=%b exp=0001", b_port_valid); end
    checks++; if (b_cnt !== 3'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", b_cnt); end
  endtask

  task automatic test_midflight_reset();
    rst_c = 1'b1; step(); rst_c = 1'b0;
    drive(1'b1, 4'h7, SOD_MODE_RR);
    drive(1'b0, 4'h0, SOD_MODE_RR);
    drive(1'b0, 4'h5, SOD_MODE_RR);
    checks++; if (c_port_out !== 16'h0007) begin failures++; $display("FAIL mf_pre_data got=%h exp=0007", c_port_out); end
    checks++; if (c_port_valid !== 4'b0001) begin failures++; $display("FAIL mf_pre_valid got=%b exp=0001", c_port_valid); end
    drive(1'b1, 4'h2, SOD_MODE_RR);
    drive(1'b0, 4'hE, SOD_MODE_RR);
    rst_c = 1'b1; #1;
    checks++; if (c_port_out !== 16'h0) begin failures++; $display("FAIL mf_port_out got=%h exp=0", c_port_out); end
    checks++; if (c_ref_q !== 4'h0) begin failures++; $display("FAIL mf_ref_q got=%h exp=0", c_ref_q); end
    checks++; if (c_cnt !== 8'h0) begin failures++; $display("FAIL mf_cnt got=%0d exp=0", c_cnt); end
    step(); step();
    rst_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, SOD_MODE_RR);
      checks++; if (c_port_valid !== 4'h0) begin failures++; $display("FAIL mf_stale_pulse i=%0d got=%b exp=0000", i, c_port_valid); end
    end
    drive(1'b1, 4'h3, SOD_MODE_RR);
    drive(1'b0, 4'h0, SOD_MODE_RR);
    drive(1'b0, 4'h0, SOD_MODE_RR);
    checks++; if (c_port_valid !== 4'b0001) begin failures++; $display("FAIL mf_first_ch got=%b exp=0001", c_port_valid); end
    checks++; if (c_port_out !== 16'h0003) begin failures++; $display("FAIL mf_first_data got=%h exp=0003", c_port_out); end
  endtask

  task automatic test_single();
    rst_d = 1'b1; step(); rst_d = 1'b0;
    drive(1'b1, 4'h5, SOD_MODE_RR);
    checks++; if (d_port_valid !== 1'b1) begin failures++; $display("FAIL d1_valid got=%b exp=1", d_port_valid); end
    checks++; if (d_port_out !== 4'hA) begin failures++; $display("FAIL d1_data got=%h exp=a", d_port_out); end
    drive(1'b1, 4'h9, SOD_MODE_BC);
    checks++; if (d_port_out !== 4'h6) begin failures++; $display("FAIL d1_bc_data got=%h exp=6", d_port_out); end
    checks++; if (d_cnt !== 8'd2) begin failures++; $display("FAIL d1_cnt got=%0d exp=2", d_cnt); end
    drive(1'b0, 4'h3, SOD_MODE_RR);
    checks++; if (d_port_valid !== 1'b0) begin failures++; $display("FAIL d1_idle got=%b exp=0", d_port_valid); end
    checks++; if (d_port_out !== 4'h6) begin failures++; $display("FAIL d1_hold got=%h exp=6", d_port_out); end
    checks++; if (dut_d.rr_ptr !== 1'b0) begin failures++; $display("FAIL d1_ptr got=%b exp=0", dut_d.rr_ptr); end
    drive(1'b1, 4'h0, SOD_MODE_RR);
    checks++; if (d_port_out !== 4'hF) begin failures++; $display("FAIL d1_rr_data got=%h exp=f", d_port_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr();
    test_broadcast();
    test_gaps();
    test_wrap();
    test_midflight_reset();
    test_single();
    drive(1'b0, 4'h0, SOD_MODE_RR);
    drive(1'b0, 4'h0, SOD_MODE_RR);
    @(negedge clk); #1;
    checks++; if (a_cnt !== 8'(cnt_a)) begin failures++; $display("FAIL final_cnt got=%0d exp=%0d", a_cnt, cnt_a); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
